// File: rtl/hour_display_ctrl.sv
// Converts the mod-12 hour count into 12-hour BCD digits with AM/PM, day count and error flags.
// Optional 7-segment outputs are enabled by defining SEG7_EN.
module hour_display_ctrl #(
    parameter int unsigned DAY_W   = 4,
    parameter int unsigned DAY_MAX = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       cnt_in,
    output logic [3:0]       hr_tens,
    output logic [3:0]       hr_units,
    output logic             pm,
    output logic [DAY_W-1:0] day_cnt,
    output logic             wrap_pulse,
    output logic             skip_err,
    output logic             range_err
`ifdef SEG7_EN
    ,
    output logic [6:0]       seg_tens,
    output logic [6:0]       seg_units
`endif
);

    localparam int unsigned HR_W = 4;

    typedef enum logic [1:0] {
        S_WAIT,
        S_TRACK,
        S_FAULT
    } state_t;

    state_t          state;
    logic [HR_W-1:0] prev;

    logic            valid_c;
    logic [HR_W-1:0] next_hr_c;
    logic [HR_W-1:0] tens_c;
    logic [HR_W-1:0] units_c;
    logic            last_day_c;

    // Active-low gfedcba pattern for one BCD digit.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    // Sample validity, expected successor and 12-hour digit decode of cnt_in.
    always_comb begin
        valid_c    = (cnt_in < HR_W'(12));
        next_hr_c  = (prev == HR_W'(11)) ? HR_W'(0) : prev + HR_W'(1);
        tens_c     = HR_W'(0);
        units_c    = cnt_in;
        last_day_c = (day_cnt == DAY_W'(DAY_MAX));
        if (cnt_in == HR_W'(0)) begin
            tens_c  = HR_W'(1);
            units_c = HR_W'(2);
        end else if (cnt_in >= HR_W'(10)) begin
            tens_c  = HR_W'(1);
            units_c = cnt_in - HR_W'(10);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_WAIT;
            prev       <= HR_W'(0);
            hr_tens    <= HR_W'(1);
            hr_units   <= HR_W'(2);
            pm         <= 1'b0;
            day_cnt    <= DAY_W'(0);
            wrap_pulse <= 1'b0;
            skip_err   <= 1'b0;
            range_err  <= 1'b0;
`ifdef SEG7_EN
            seg_tens   <= 7'h79;
            seg_units  <= 7'h24;
`endif
        end else begin
            wrap_pulse <= 1'b0;
            if (!valid_c) begin
                state     <= S_FAULT;
                range_err <= 1'b1;
            end else if (state != S_TRACK || cnt_in != prev) begin
                // Any accepted new value updates the digits; only TRACK checks continuity.
                state    <= S_TRACK;
                prev     <= cnt_in;
                hr_tens  <= tens_c;
                hr_units <= units_c;
`ifdef SEG7_EN
                seg_tens  <= (tens_c == HR_W'(0)) ? 7'h7F : seg7(tens_c);
                seg_units <= seg7(units_c);
`endif
                if (state == S_TRACK) begin
                    if (cnt_in != next_hr_c) begin
                        skip_err <= 1'b1;
                    end else if (prev == HR_W'(11)) begin
                        wrap_pulse <= 1'b1;
                        pm         <= ~pm;
                        if (pm) begin
                            day_cnt <= last_day_c ? DAY_W'(0) : day_cnt + DAY_W'(1);
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hour_display_ctrl.sv
// Scoreboard bench for hour_display_ctrl: directed sequences plus randomized counts vs a behavioural model.
module tb_hour_display_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] cnt_in = 4'd0;
    logic [3:0] hr_tens, hr_units;
    logic       pm;
    logic [3:0] day_cnt;
    logic       wrap_pulse, skip_err, range_err;
`ifdef SEG7_EN
    logic [6:0] seg_tens, seg_units;
`endif

    hour_display_ctrl #(.DAY_W(4), .DAY_MAX(9)) dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_in     (cnt_in),
        .hr_tens    (hr_tens),
        .hr_units   (hr_units),
        .pm         (pm),
        .day_cnt    (day_cnt),
        .wrap_pulse (wrap_pulse),
        .skip_err   (skip_err),
        .range_err  (range_err)
`ifdef SEG7_EN
        ,
        .seg_tens   (seg_tens),
        .seg_units  (seg_units)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
        logic       pm;
        logic [3:0] day;
        logic       wrap;
        logic       skip;
        logic       rng;
`ifdef SEG7_EN
        logic [6:0] segt;
        logic [6:0] segu;
`endif
    } obs_t;

    logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Behavioural model: shown hour, AM/PM, days and sticky flags.
    int m_prev, m_tens, m_units, m_day;
    bit m_fresh, m_pm, m_wrap, m_skip, m_rng;

    obs_t q[$];
    int   checks = 0;
    int   passes = 0;
    int   sample_no = 0;

    function automatic obs_t snap();
        obs_t o;
        o.tens  = hr_tens;
        o.units = hr_units;
        o.pm    = pm;
        o.day   = day_cnt;
        o.wrap  = wrap_pulse;
        o.skip  = skip_err;
        o.rng   = range_err;
`ifdef SEG7_EN
        o.segt  = seg_tens;
        o.segu  = seg_units;
`endif
        return o;
    endfunction

    function automatic obs_t model_out();
        obs_t o;
        o.tens  = 4'(m_tens);
        o.units = 4'(m_units);
        o.pm    = m_pm;
        o.day   = 4'(m_day);
        o.wrap  = m_wrap;
        o.skip  = m_skip;
        o.rng   = m_rng;
`ifdef SEG7_EN
        o.segt  = (m_tens == 0) ? 7'h7F : seg_lut[m_tens];
        o.segu  = seg_lut[m_units];
`endif
        return o;
    endfunction

    task automatic model_reset();
        m_fresh = 1; m_prev = 0; m_tens = 1; m_units = 2;
        m_pm = 0; m_day = 0; m_wrap = 0; m_skip = 0; m_rng = 0;
    endtask

    task automatic model_show(input int v);
        m_prev  = v;
        m_tens  = (v == 0) ? 1 : v / 10;
        m_units = (v == 0) ? 2 : v % 10;
    endtask

    task automatic model_step(input int v);
        m_wrap = 0;
        if (v >= 12) begin
            m_rng   = 1;
            m_fresh = 1;
        end else if (m_fresh) begin
            m_fresh = 0;
            model_show(v);
        end else if (v == m_prev) begin
            // steady count: nothing changes
        end else if (v == (m_prev + 1) % 12) begin
            if (m_prev == 11) begin
                m_wrap = 1;
                m_pm   = !m_pm;
                if (!m_pm) m_day = (m_day + 1) % 10;
            end
            model_show(v);
        end else begin
            m_skip = 1;
            model_show(v);
        end
    endtask

    task automatic check(input obs_t got, input obs_t exp, input string tag);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got tens=%0d units=%0d pm=%0b day=%0d wrap=%0b skip=%0b rng=%0b (%h), want tens=%0d units=%0d pm=%0b day=%0d wrap=%0b skip=%0b rng=%0b (%h)",
                      tag, got.tens, got.units, got.pm, got.day, got.wrap, got.skip, got.rng, got,
                      exp.tens, exp.units, exp.pm, exp.day, exp.wrap, exp.skip, exp.rng, exp);
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input int v);
        cnt_in = 4'(v);
        model_step(v);
        q.push_back(model_out());
        @(negedge clk);
    endtask

    // Async reset check is taken 1 time unit after rst rises, before any clock edge.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1 check(snap(), model_out(), "async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares each registered response one time unit after its edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                obs_t e;
                string tag;
                e = q.pop_front();
                sample_no++;
                tag = $sformatf("sample_%0d", sample_no);
                check(snap(), e, tag);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int r;
        model_reset();
        @(negedge clk);
        do_reset();

        // Steady zero never wraps.
        for (int i = 0; i < 5; i++) drive(0);

        // One full cycle with wrap, then 24 cycles for day rollover.
        do_reset();
        for (int i = 0; i < 12; i++) drive(i);
        drive(0);
        drive(0);
        do_reset();
        for (int c = 0; c < 24; c++)
            for (int i = 0; i < 12; i++) drive(i);
        drive(0);

        // Skip detection.
        do_reset();
        drive(3); drive(4); drive(7); drive(7); drive(8);

        // Out-of-range sample, recovery without skip.
        do_reset();
        drive(5); drive(13); drive(6); drive(7);

        // Reset mid-count while PM, then restart at 4.
        do_reset();
        for (int i = 0; i < 12; i++) drive(i);
        for (int i = 0; i <= 8; i++) drive(i);
        do_reset();
        drive(4); drive(5);

        // Randomized mix of holds, increments, jumps, invalid counts and resets.
        do_reset();
        v = 0;
        for (int n = 0; n < 2500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) begin
                do_reset();
            end else begin
                if (r < 45)      v = (v >= 12) ? 0 : v;
                else if (r < 88) v = (v >= 11) ? 0 : v + 1;
                else if (r < 95) v = int'($urandom_range(0, 11));
                else             v = int'($urandom_range(12, 15));
                drive(v);
            end
        end

        @(negedge clk);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
